ram_access_ctrl: RTL and testbench
==================================

// Module: ram_access_ctrl
// PURPOSE
//  Request/response front-end for the single-port word RAM (32 x 32, sync write, registered read addr).
//  Accepts CPU load/store requests and drives the RAM data/addr/wr/enable pins.
//  Captures q one edge after the address is registered and returns it on a held response.
//  Byte-enabled stores are performed as read-modify-write.
// PARAMETERS
//  DEPTH   32  RAM words; must equal the attached RAM depth
//  ADDR_W  5   word-index width, clog2(DEPTH)
// PORTS
//  clk         in   1   single clock, rising edge
//  rst_n       in   1   asynchronous, active-low reset
//  req_valid   in   1   request present
//  req_ready   out  1   controller can accept a request
//  req_wr      in   1   1 = store, 0 = load
//  req_addr    in   32  byte address; word index = req_addr[ADDR_W+1:2]
//  req_wdata   in   32  store data
//  req_be      in   4   store byte enables; be[i] selects bits 8i+7:8i
//  resp_valid  out  1   response present, held until accepted
//  resp_ready  in   1   consumer accepts response
//  resp_rdata  out  32  load data (0 for stores)
//  resp_err    out  1   address error (see CONFIGURATION)
//  ram_data    out  32  to RAM data
//  ram_addr    out  32  to RAM addr; zero-extended word index
//  ram_wr      out  1   to RAM wr
//  ram_en      out  1   to RAM enable
//  ram_q       in   32  from RAM q
// BEHAVIOUR
//  States: IDLE, RD, RD_WAIT, WR, RESP. Reset -> IDLE; all regs 0.
//  Reset outputs: req_ready=0 while rst_n=0, resp_valid=0, resp_rdata=0, resp_err=0, ram_en=0, ram_wr=0.
//  IDLE: req_ready=1. Accept on req_valid&req_ready; latch wr/index/wdata/be.
//   - store, be=4'hF -> WR
//   - store, be=4'h0 -> RESP (no RAM access)
//   - store, partial be -> RD
//   - load -> RD
//  RD: ram_en=1, ram_wr=0, ram_addr=index -> RD_WAIT (RAM registers the addr on this edge).
//  RD_WAIT: ram_en=0; ram_q is valid.
//   - load: resp_rdata<=ram_q -> RESP
//   - store: merged<=(ram_q & ~mask) | (wdata & mask), mask = be expanded to bytes -> WR
//  WR: ram_en=1, ram_wr=1, ram_addr=index, ram_data=merged (full store: wdata) -> RESP.
//  RESP: resp_valid=1 until resp_ready; resp_rdata/resp_err stable while held; then -> IDLE.
//  Latency, accept edge to resp_valid high (edges):
//   - full store 2
//   - load 3
//   - partial store 4
//   - be=0 store 1
//  One transaction in flight. req_ready=0 outside IDLE, including the RESP cycle.
//  ram_en=0 in IDLE and RESP; ram_wr is never 1 without ram_en.
//  rst_n low mid-transaction: abort, no response.
//   - Async reset drops ram_en immediately; a WR is not committed unless its edge preceded the reset.
//   - RAM contents are not reset.
// CONFIGURATION
//  Macro RAM_ACCESS_CTRL_ADDR_CHECK_EN:
//   - Defined: a request with req_addr[31:2] >= DEPTH or req_addr[1:0] != 0 goes IDLE -> RESP directly,
//     with resp_err=1 and resp_rdata=0. No RAM access (ram_en stays 0).
//   - Undefined: req_addr[1:0] and bits above ADDR_W+1 are ignored (index wraps); resp_err tied 0.
// TESTING
//  1 rst_n=0 with req_valid=1 -> req_ready=0, ram_en=0; release -> req_ready=1 next cycle.
//  2 store 0xDEADBEEF @0x10 be=F, then load @0x10 -> store resp at +2 edges; load resp at +3 with 0xDEADBEEF.
//  3 store 0x0000AB00 @0x10 be=4'b0010 -> one read plus one write cycle on RAM pins; later load returns 0xDEADABEF.
//  4 load with resp_ready=0 for 3 cycles -> resp_valid held, rdata stable, req_ready=0; accepted on 4th -> IDLE.
//  5 load @0x80: with _EN -> resp_err=1 after 1 edge, ram_en never 1; without -> data of word 0.
//  6 rst_n pulsed low while in RD_WAIT -> no resp_valid; next load is served normally.

Source files
------------

// File: rtl/ram_access_ctrl.sv
// ram_access_ctrl: request/response front-end for a single-port 32-bit word RAM
// (sync write, registered read address, q valid one edge after the address).
// Loads are read, stores with all byte enables are written directly, partial
// stores are done as read-modify-write, and stores with no enables respond
// without touching the RAM. One transaction is in flight at a time.
//
// Optional build macro: RAM_ACCESS_CTRL_ADDR_CHECK_EN
//   defined   -> out-of-range or misaligned byte addresses answer with resp_err=1
//                and never reach the RAM
//   undefined -> word index wraps, low/high address bits ignored, resp_err=0
module ram_access_ctrl #(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  // CPU request
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  // CPU response
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  // RAM pins
  output logic [31:0] ram_data,
  output logic [31:0] ram_addr,
  output logic        ram_wr,
  output logic        ram_en,
  input  logic [31:0] ram_q
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_RD      = 3'd1;
  localparam logic [2:0] ST_RD_WAIT = 3'd2;
  localparam logic [2:0] ST_WR      = 3'd3;
  localparam logic [2:0] ST_RESP    = 3'd4;

  // Expand 4 byte enables into a 32-bit bit mask.
  function automatic logic [31:0] be_to_mask(input logic [3:0] be);
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{be[i]}};
    return m;
  endfunction

  logic [2:0]        state_q,  state_d;
  logic              init_q,   init_d;
  logic              wr_q,     wr_d;
  logic [ADDR_W-1:0] idx_q,    idx_d;
  logic [31:0]       wdata_q,  wdata_d;
  logic [31:0]       mask_q,   mask_d;
  logic [31:0]       merged_q, merged_d;
  logic [31:0]       rdata_q,  rdata_d;
  logic              err_q,    err_d;

  logic              accept;
  logic              addr_bad;

`ifdef RAM_ACCESS_CTRL_ADDR_CHECK_EN
  // Word index beyond the RAM, or a byte address not on a word boundary.
  assign addr_bad = (req_addr[31:2] >= 30'(DEPTH)) || (req_addr[1:0] != 2'b00);
`else
  // Index wraps; the bits outside the word index carry no meaning here.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{req_addr[31:ADDR_W+2], req_addr[1:0]};
  assign addr_bad         = 1'b0;
`endif

  // Ready only once out of reset and with nothing in flight (RESP included).
  assign req_ready  = init_q && (state_q == ST_IDLE);
  assign accept     = req_valid && req_ready;

  assign resp_valid = (state_q == ST_RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

  // RAM is driven only in RD and WR, so an async reset drops ram_en at once.
  assign ram_en     = (state_q == ST_RD) || (state_q == ST_WR);
  assign ram_wr     = (state_q == ST_WR);
  assign ram_addr   = {{(32-ADDR_W){1'b0}}, idx_q};
  assign ram_data   = merged_q;

  // Next-state and datapath: latch the request, merge on RMW, capture load data.
  always_comb begin
    state_d  = state_q;
    init_d   = 1'b1;
    wr_d     = wr_q;
    idx_d    = idx_q;
    wdata_d  = wdata_q;
    mask_d   = mask_q;
    merged_d = merged_q;
    rdata_d  = rdata_q;
    err_d    = err_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          wr_d     = req_wr;
          idx_d    = req_addr[ADDR_W+1:2];
          wdata_d  = req_wdata;
          mask_d   = be_to_mask(req_be);
          // A full store writes wdata as-is; a partial one overwrites this in RD_WAIT.
          merged_d = req_wdata;
          rdata_d  = '0;
          err_d    = 1'b0;
          if (addr_bad) begin
            err_d   = 1'b1;
            state_d = ST_RESP;
          end else if (req_wr) begin
            if (req_be == 4'hF)      state_d = ST_WR;
            else if (req_be == 4'h0) state_d = ST_RESP;
            else                     state_d = ST_RD;
          end else begin
            state_d = ST_RD;
          end
        end
      end
      // RAM registers the read address on the edge leaving RD.
      ST_RD:      state_d = ST_RD_WAIT;
      // ram_q now reflects the addressed word.
      ST_RD_WAIT: begin
        if (wr_q) begin
          merged_d = (ram_q & ~mask_q) | (wdata_q & mask_q);
          state_d  = ST_WR;
        end else begin
          rdata_d  = ram_q;
          state_d  = ST_RESP;
        end
      end
      ST_WR:      state_d = ST_RESP;
      ST_RESP: begin
        if (resp_ready) state_d = ST_IDLE;
      end
      default:    state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; everything clears on async reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      init_q   <= 1'b0;
      wr_q     <= 1'b0;
      idx_q    <= '0;
      wdata_q  <= '0;
      mask_q   <= '0;
      merged_q <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      init_q   <= init_d;
      wr_q     <= wr_d;
      idx_q    <= idx_d;
      wdata_q  <= wdata_d;
      mask_q   <= mask_d;
      merged_q <= merged_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Bench for ram_access_ctrl: attaches a 32x32 RAM model (sync write, registered
// read address), keeps a transaction-level reference (shadow memory, expected
// latency, expected RAM traffic) and compares every negedge.
module tb_ram_access_ctrl;

  logic        clk, rst_n;
  logic        req_valid, req_ready, req_wr;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] ram_data, ram_addr, ram_q;
  logic        ram_wr, ram_en;

  int errs = 0;
  int nchk = 0;

  ram_access_ctrl #(.DEPTH(32), .ADDR_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .ram_data(ram_data), .ram_addr(ram_addr), .ram_wr(ram_wr),
    .ram_en(ram_en), .ram_q(ram_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM: contents are never reset.
  logic [31:0] mem [32];
  logic [4:0]  raddr = '0;
  always @(posedge clk) begin
    if (ram_en) begin
      raddr <= ram_addr[4:0];
      if (ram_wr) mem[ram_addr[4:0]] <= ram_data;
    end
  end
  assign ram_q = mem[raddr];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction-level reference model.
  logic [31:0] shadow [32];
  logic        pending, init;
  int          rem;
  logic [31:0] exp_rdata, exp_wdata;
  logic        exp_err;
  logic [4:0]  exp_idx;
  int          exp_nrd, exp_nwr;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending = 1'b0;
      init    = 1'b0;
      rem     = 0;
    end else begin
      if (pending) begin
        if (rem > 0) rem--;
        else if (resp_ready) pending = 1'b0;
      end else if (init && req_valid) begin
        logic        bad;
        logic [31:0] m;
        int          lat;
        bad = 1'b0;
`ifdef RAM_ACCESS_CTRL_ADDR_CHECK_EN
        bad = (req_addr[31:2] >= 30'd32) || (req_addr[1:0] != 2'b00);
`endif
        m = {{8{req_be[3]}}, {8{req_be[2]}}, {8{req_be[1]}}, {8{req_be[0]}}};
        exp_idx   = req_addr[6:2];
        exp_err   = bad;
        exp_rdata = '0;
        exp_nrd   = 0;
        exp_nwr   = 0;
        if (bad) lat = 1;
        else if (!req_wr) begin
          lat = 3; exp_rdata = shadow[exp_idx]; exp_nrd = 1;
        end else if (req_be == 4'h0) lat = 1;
        else begin
          exp_wdata = (shadow[exp_idx] & ~m) | (req_wdata & m);
          shadow[exp_idx] = exp_wdata;
          exp_nwr = 1;
          if (req_be == 4'hF) lat = 2;
          else begin lat = 4; exp_nrd = 1; end
        end
        rem     = lat - 1;
        pending = 1'b1;
      end
      init = 1'b1;
    end
  end

  // Per-cycle compare against the reference model.
  int nrd, nwr;
  initial begin
    nrd = 0; nwr = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst req_ready", {31'b0, req_ready}, 0);
        chk("rst ram_en", {31'b0, ram_en}, 0);
        chk("rst resp_valid", {31'b0, resp_valid}, 0);
        nrd = 0; nwr = 0;
      end else begin
        logic ev;
        ev = pending && (rem == 0);
        chk("req_ready", {31'b0, req_ready}, {31'b0, init && !pending});
        chk("resp_valid", {31'b0, resp_valid}, {31'b0, ev});
        chk("wr without en", {31'b0, ram_wr & ~ram_en}, 0);
        if (!pending) begin nrd = 0; nwr = 0; end
        if (!pending || rem == 0) chk("ram_en idle/resp", {31'b0, ram_en}, 0);
        else if (ram_en) begin
          chk("ram_addr", ram_addr, {27'b0, exp_idx});
          if (ram_wr) begin nwr++; chk("ram_data", ram_data, exp_wdata); end
          else nrd++;
        end
        if (ev) begin
          chk("resp_rdata", resp_rdata, exp_rdata);
          chk("resp_err", {31'b0, resp_err}, {31'b0, exp_err});
          chk("ram reads", nrd, exp_nrd);
          chk("ram writes", nwr, exp_nwr);
        end
      end
    end
  end

  // One request/response; hold = cycles resp_ready stays low once resp_valid is up.
  task automatic txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] be, input int hold,
                     output logic [31:0] rd, output logic er, output int lat);
    int n;
    logic [31:0] first;
    req_valid = 1'b1; req_wr = wr; req_addr = addr; req_wdata = wdata; req_be = be;
    n = 0;
    while (!req_ready && n < 50) begin @(posedge clk); #1; n++; end
    if (!req_ready) chk("accept timeout", 1, 0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    if (!resp_valid) chk("resp timeout", 1, 0);
    first = resp_rdata;
    for (int i = 0; i < hold; i++) begin
      chk("held rdata", resp_rdata, first);
      chk("held valid", {31'b0, resp_valid}, 1);
      chk("held ready", {31'b0, req_ready}, 0);
      @(posedge clk); #1;
    end
    resp_ready = 1'b1;
    rd = resp_rdata; er = resp_err;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    chk("back to idle", {31'b0, req_ready}, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL global timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    rst_n = 1'b0; req_valid = 1'b1; req_wr = 1'b0; req_addr = '0;
    req_wdata = '0; req_be = '0; resp_ready = 1'b0;

    // Reset with a pending request
    repeat (3) @(negedge clk);
    chk("t1 ready in reset", {31'b0, req_ready}, 0);
    chk("t1 en in reset", {31'b0, ram_en}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("t1 ready after release", {31'b0, req_ready}, 1);
    req_valid = 1'b0;
    @(posedge clk); #1;

    // Full store then load
    txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, rd, er, lat);
    chk("t2 store lat", lat, 2);
    chk("t2 store rdata", rd, 0);
    txn(1'b0, 32'h10, 32'h0, 4'h0, 0, rd, er, lat);
    chk("t2 load lat", lat, 3);
    chk("t2 load data", rd, 32'hDEADBEEF);

    // Word 0 for the wrap test
    txn(1'b1, 32'h0, 32'h12345678, 4'hF, 0, rd, er, lat);
    chk("w0 store lat", lat, 2);

    // Partial store (RMW) then load
    txn(1'b1, 32'h10, 32'h0000AB00, 4'b0010, 0, rd, er, lat);
    chk("t3 rmw lat", lat, 4);
    txn(1'b0, 32'h10, 32'h0, 4'h0, 0, rd, er, lat);
    chk("t3 load data", rd, 32'hDEADABEF);

    // be=0 store: no RAM access, data unchanged
    txn(1'b1, 32'h10, 32'hFFFFFFFF, 4'h0, 0, rd, er, lat);
    chk("be0 lat", lat, 1);

    // Response back-pressure for 3 cycles
    txn(1'b0, 32'h10, 32'h0, 4'h0, 3, rd, er, lat);
    chk("t4 held load data", rd, 32'hDEADABEF);

    // Out-of-range load
    txn(1'b0, 32'h80, 32'h0, 4'h0, 0, rd, er, lat);
`ifdef RAM_ACCESS_CTRL_ADDR_CHECK_EN
    chk("t5 err", {31'b0, er}, 1);
    chk("t5 lat", lat, 1);
    chk("t5 rdata", rd, 0);
`else
    chk("t5 err", {31'b0, er}, 0);
    chk("t5 lat", lat, 3);
    chk("t5 wrapped data", rd, 32'h12345678);
`endif

    // Reset pulse while in RD_WAIT
    req_valid = 1'b1; req_wr = 1'b0; req_addr = 32'h10; req_be = 4'h0;
    @(posedge clk); #1;  // accept edge -> RD
    req_valid = 1'b0;
    @(posedge clk); #1;  // -> RD_WAIT
    rst_n = 1'b0; #2; rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("t6 no resp after abort", {31'b0, resp_valid}, 0);
    end
    txn(1'b0, 32'h10, 32'h0, 4'h0, 0, rd, er, lat);
    chk("t6 load after abort", rd, 32'hDEADABEF);
    chk("t6 lat", lat, 3);

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end

endmodule
